// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the riscv_mem_arb memory arbiter.
//   biu_size_t : access size carried on the core data port and the shared bus.
package riscv_mem_arb_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } biu_size_t;

endpackage

// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: shares one external memory bus between the core's fetch port
// and data port. Data has priority, and a starvation guard forces a fetch
// grant after STARVE_MAX consecutive data grants. A watchdog aborts bus
// transactions that never complete. Flushed fetches are drained silently.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   imem_req_i/adr_i/flush_i         fetch request, address, pipeline flush
//   imem_q_o/ack_o/err_o             fetch data and completion pulses
//   dmem_req_i/we_i/adr_i/d_i/size_i data request and qualifiers
//   dmem_q_o/ack_o/err_o             data read data and completion pulses
//   bus_req_o/we_o/adr_o/d_o/size_o  registered shared-bus request
//   bus_q_i/ack_i/err_i              shared-bus read data and completion
//
// state  | meaning
// IDLE   | no transaction on the bus; grant decided here
// IGNT   | fetch transaction active
// DGNT   | data transaction active
// IDRAIN | flushed fetch still on the bus; its completion is absorbed
module riscv_mem_arb
   import riscv_mem_arb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            imem_req_i,
   input  logic [XLEN-1:0] imem_adr_i,
   input  logic            imem_flush_i,
   output logic [XLEN-1:0] imem_q_o,
   output logic            imem_ack_o,
   output logic            imem_err_o,
   input  logic            dmem_req_i,
   input  logic            dmem_we_i,
   input  logic [XLEN-1:0] dmem_adr_i,
   input  logic [XLEN-1:0] dmem_d_i,
   input  biu_size_t       dmem_size_i,
   output logic [XLEN-1:0] dmem_q_o,
   output logic            dmem_ack_o,
   output logic            dmem_err_o,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_adr_o,
   output logic [XLEN-1:0] bus_d_o,
   output biu_size_t       bus_size_o,
   input  logic [XLEN-1:0] bus_q_i,
   input  logic            bus_ack_i,
   input  logic            bus_err_i
);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT, IDRAIN} state_t;

   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [15:0] WDOG_LIM   = 16'(TIMEOUT);

   state_t          state_q, state_d;
   logic [3:0]      starve_q, starve_d;
   logic [15:0]     wdog_q, wdog_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [XLEN-1:0] bus_adr_q, bus_adr_d;
   logic [XLEN-1:0] bus_d_q, bus_d_d;
   biu_size_t       bus_size_q, bus_size_d;

   logic active, wd_to, done, in_i, in_d, bus_end;

   assign active  = (state_q != IDLE);
   assign wd_to   = active && (wdog_q == WDOG_LIM);
   assign bus_end = bus_ack_i | bus_err_i;
   assign done    = active && (bus_end || wd_to);
   assign in_i    = (state_q == IGNT);
   assign in_d    = (state_q == DGNT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         wdog_q     <= '0;
         bus_req_q  <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_adr_q  <= '0;
         bus_d_q    <= '0;
         bus_size_q <= SIZE_BYTE;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         wdog_q     <= wdog_d;
         bus_req_q  <= bus_req_d;
         bus_we_q   <= bus_we_d;
         bus_adr_q  <= bus_adr_d;
         bus_d_q    <= bus_d_d;
         bus_size_q <= bus_size_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      wdog_d     = wdog_q;
      bus_req_d  = bus_req_q;
      bus_we_d   = bus_we_q;
      bus_adr_d  = bus_adr_q;
      bus_d_d    = bus_d_q;
      bus_size_d = bus_size_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            // data wins unless the fetch port has already waited STARVE_MAX grants
            if (dmem_req_i && (!imem_req_i || (starve_q != STARVE_LIM))) begin
               state_d    = DGNT;
               starve_d   = imem_req_i ? (starve_q + 4'd1) : 4'd0;
               bus_req_d  = 1'b1;
               bus_we_d   = dmem_we_i;
               bus_adr_d  = dmem_adr_i;
               bus_d_d    = dmem_d_i;
               bus_size_d = dmem_size_i;
            end else if (imem_req_i) begin
               state_d    = IGNT;
               starve_d   = '0;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_adr_d  = imem_adr_i;
               bus_d_d    = '0;
               bus_size_d = SIZE_WORD;
            end
         end
         IGNT: begin
            wdog_d = wdog_q + 16'd1;
            // completion takes precedence: a flush together with ack just returns to IDLE
            if (done) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
            end else if (imem_flush_i) begin
               state_d = IDRAIN;
            end
         end
         DGNT, IDRAIN: begin
            wdog_d = wdog_q + 16'd1;
            if (done) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus_req_o  = bus_req_q;
   assign bus_we_o   = bus_we_q;
   assign bus_adr_o  = bus_adr_q;
   assign bus_d_o    = bus_d_q;
   assign bus_size_o = bus_size_q;

   // error beats ack; a flush in the completion cycle discards the fetch result
   assign imem_ack_o = in_i && bus_ack_i && !bus_err_i && !imem_flush_i;
   assign imem_err_o = in_i && (bus_err_i || wd_to) && !imem_flush_i;
   assign imem_q_o   = (in_i && bus_end) ? bus_q_i : '0;
   assign dmem_ack_o = in_d && bus_ack_i && !bus_err_i;
   assign dmem_err_o = in_d && (bus_err_i || wd_to);
   assign dmem_q_o   = (in_d && bus_end) ? bus_q_i : '0;

endmodule

// File: tb/tb_riscv_mem_arb.sv
module tb_riscv_mem_arb;
   import riscv_mem_arb_pkg::*;

   logic        clk_i, rst_ni;
   logic        imem_req_i, imem_flush_i;
   logic [31:0] imem_adr_i, imem_q_o;
   logic        imem_ack_o, imem_err_o;
   logic        dmem_req_i, dmem_we_i;
   logic [31:0] dmem_adr_i, dmem_d_i, dmem_q_o;
   biu_size_t   dmem_size_i;
   logic        dmem_ack_o, dmem_err_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_adr_o, bus_d_o, bus_q_i;
   biu_size_t   bus_size_o;
   logic        bus_ack_i, bus_err_i;

   int n_tot = 0;
   int n_bad = 0;

   riscv_mem_arb #(.XLEN(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .imem_req_i(imem_req_i), .imem_adr_i(imem_adr_i), .imem_flush_i(imem_flush_i),
      .imem_q_o(imem_q_o), .imem_ack_o(imem_ack_o), .imem_err_o(imem_err_o),
      .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_adr_i(dmem_adr_i),
      .dmem_d_i(dmem_d_i), .dmem_size_i(dmem_size_i),
      .dmem_q_o(dmem_q_o), .dmem_ack_o(dmem_ack_o), .dmem_err_o(dmem_err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
      .bus_d_o(bus_d_o), .bus_size_o(bus_size_o),
      .bus_q_i(bus_q_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // both ports request continuously on a zero-wait bus; every fifth grant is the fetch
   task automatic run_pair(input int n);
      imem_req_i = 1'b1; imem_adr_i = 32'h1000;
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_adr_i = 32'h2000; dmem_size_i = SIZE_WORD;
      for (int g = 0; g < n; g++) begin
         int  w;
         logic exp_d;
         w = 0;
         while (!bus_req_o && w < 5) begin
            cyc();
            w++;
         end
         chk("pair_wait", 32'(w < 5), 32'd1);
         exp_d = ((g % 5) != 4);
         chk("pair_owner", bus_adr_o, exp_d ? 32'h2000 : 32'h1000);
         bus_ack_i = 1'b1;
         #1;
         chk("pair_ack", {30'd0, imem_ack_o, dmem_ack_o}, exp_d ? 32'd1 : 32'd2);
         cyc();
         bus_ack_i = 1'b0;
      end
      imem_req_i = 1'b0;
      dmem_req_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      imem_req_i = 0; imem_adr_i = 0; imem_flush_i = 0;
      dmem_req_i = 0; dmem_we_i = 0; dmem_adr_i = 0; dmem_d_i = 0; dmem_size_i = SIZE_BYTE;
      bus_q_i = 0; bus_ack_i = 0; bus_err_i = 0;
      #2;
      chk("rst_bus_req", bus_req_o, 0);
      chk("rst_bus_adr", bus_adr_o, 0);
      chk("rst_outs", {imem_ack_o, imem_err_o, dmem_ack_o, dmem_err_o}, 0);
      cyc(); cyc();
      rst_ni = 1'b1;

      // single fetch, ack three cycles after bus_req_o rises
      imem_req_i = 1'b1; imem_adr_i = 32'h200;
      cyc();
      chk("f_req", bus_req_o, 1);
      chk("f_adr", bus_adr_o, 32'h200);
      chk("f_we", bus_we_o, 0);
      chk("f_size", bus_size_o, SIZE_WORD);
      chk("f_d", bus_d_o, 0);
      repeat (3) begin
         chk("f_noack", imem_ack_o, 0);
         cyc();
      end
      bus_ack_i = 1'b1; bus_q_i = 32'h13;
      #1;
      chk("f_ack", imem_ack_o, 1);
      chk("f_q", imem_q_o, 32'h13);
      chk("f_dack", dmem_ack_o, 0);
      cyc();
      bus_ack_i = 1'b0; bus_q_i = 32'h0;
      imem_req_i = 1'b0;
      chk("f_done_req", bus_req_o, 0);
      chk("f_done_ack", imem_ack_o, 0);
      cyc();
      chk("f_idle", bus_req_o, 0);

      // starvation guard
      run_pair(10);

      // flush one cycle before ack, data pending behind it
      cyc();
      imem_req_i = 1'b1; imem_adr_i = 32'h300;
      cyc();
      chk("fl_adr", bus_adr_o, 32'h300);
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_adr_i = 32'h400;
      dmem_d_i = 32'hCAFE; dmem_size_i = SIZE_BYTE;
      cyc();
      imem_flush_i = 1'b1; imem_req_i = 1'b0;
      cyc();
      imem_flush_i = 1'b0;
      chk("fl_hold", bus_req_o, 1);
      bus_ack_i = 1'b1; bus_q_i = 32'h77;
      #1;
      chk("fl_absorb", {imem_ack_o, imem_err_o, dmem_ack_o}, 0);
      cyc();
      bus_ack_i = 1'b0;
      chk("fl_drop", bus_req_o, 0);
      cyc();
      chk("fl_dgnt", {bus_req_o, bus_we_o}, 2'b11);
      chk("fl_dadr", bus_adr_o, 32'h400);
      chk("fl_dd", bus_d_o, 32'hCAFE);
      chk("fl_dsize", bus_size_o, SIZE_BYTE);
      bus_ack_i = 1'b1;
      #1;
      chk("fl_dack", dmem_ack_o, 1);
      cyc();
      bus_ack_i = 1'b0; dmem_req_i = 1'b0;

      // flush coinciding with ack
      cyc();
      imem_req_i = 1'b1; imem_adr_i = 32'h340;
      cyc();
      imem_flush_i = 1'b1; imem_req_i = 1'b0; bus_ack_i = 1'b1; bus_q_i = 32'h99;
      #1;
      chk("fa_noack", imem_ack_o, 0);
      cyc();
      imem_flush_i = 1'b0; bus_ack_i = 1'b0;
      chk("fa_idle", bus_req_o, 0);

      // watchdog on a data write that is never acked
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_adr_i = 32'h500; dmem_d_i = 32'h55;
      dmem_size_i = SIZE_WORD;
      cyc();
      chk("wd_req", bus_req_o, 1);
      repeat (8) begin
         chk("wd_early", dmem_err_o, 0);
         cyc();
      end
      chk("wd_err", dmem_err_o, 1);
      chk("wd_req_held", bus_req_o, 1);
      cyc();
      dmem_req_i = 1'b0;
      chk("wd_drop", bus_req_o, 0);
      chk("wd_err_end", dmem_err_o, 0);
      bus_ack_i = 1'b1; bus_q_i = 32'hBEEF;
      #1;
      chk("wd_late", {imem_ack_o, dmem_ack_o}, 0);
      chk("wd_late_q", dmem_q_o, 0);
      cyc();
      bus_ack_i = 1'b0;
      chk("wd_idle", bus_req_o, 0);

      // error beats ack on a data read
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_adr_i = 32'h600;
      cyc();
      bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_q_i = 32'hDEAD;
      #1;
      chk("ep_err", dmem_err_o, 1);
      chk("ep_ack", dmem_ack_o, 0);
      chk("ep_q", dmem_q_o, 32'hDEAD);
      cyc();
      bus_ack_i = 1'b0; bus_err_i = 1'b0; dmem_req_i = 1'b0;

      // async reset while a data transaction is on the bus
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_adr_i = 32'h700; dmem_d_i = 32'h77;
      dmem_size_i = SIZE_HALF;
      cyc();
      chk("ar_pre", {bus_req_o, bus_we_o}, 2'b11);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("ar_ctl", {bus_req_o, bus_we_o}, 0);
      chk("ar_adr", bus_adr_o, 0);
      chk("ar_d", bus_d_o, 0);
      chk("ar_size", bus_size_o, 0);
      cyc();
      bus_ack_i = 1'b1; bus_q_i = 32'h1234;
      #1;
      chk("ar_outs", {dmem_ack_o, dmem_err_o, imem_ack_o}, 0);
      chk("ar_q", dmem_q_o, 0);
      bus_ack_i = 1'b0; dmem_req_i = 1'b0;
      rst_ni = 1'b1;
      cyc();
      chk("ar_idle", bus_req_o, 0);
      run_pair(5);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
